// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front end: the fetch buffer entry and
// the PC arithmetic used for sequential and branch redirection.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  // Delta counts instruction words; the target stays word aligned for aligned bases.
  function automatic logic [ADDR_W-1:0] branch_target(
    input logic [ADDR_W-1:0] base,
    input logic [ADDR_W-1:0] delta
  );
    return base + (delta << 2);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel and the Decode hand-off channel
// of the fetch unit. The master side is the fetch unit itself.
interface fetch_unit_if;
  import cpu_pkg::*;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ready;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  logic               dec_valid;
  logic [INSTR_W-1:0] dec_instr;
  logic [ADDR_W-1:0]  dec_pc;
  logic               dec_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata,
    output dec_valid, dec_instr, dec_pc,
    input  dec_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata,
    input  dec_valid, dec_instr, dec_pc,
    output dec_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// First-word fall-through instruction buffer with wrap-around pointers.
// Flush empties the buffer in one cycle and overrides any push or pop.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter  int FIFO_DEPTH = 2,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  fetch_entry_t     mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: the storage array is reset as well, so the head reads as all zeros
  // from reset until the first word is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: non-blocking updates keep every register reading its pre-edge value.
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: drives the PC, issues credit-limited imem reads, buffers the
// returned words and redirects on taken branches, discarding stale responses.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                FIFO_DEPTH      = 2,
  parameter int                MAX_OUTSTANDING = 2,
  parameter logic [ADDR_W-1:0] RESET_PC        = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_base_pc,
  input  logic [ADDR_W-1:0] br_delta,
  fetch_unit_if.master      bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [ADDR_W-1:0] pc;
  logic [OUT_W-1:0]  inflight;
  logic [OUT_W-1:0]  drop;
  logic [OUT_W-1:0]  live;
  logic [ADDR_W-1:0] occupancy;
  logic              accept;
  logic              resp_live;
  logic [ADDR_W-1:0] resp_pc;

  fetch_entry_t      push_entry;
  fetch_entry_t      fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_pop;

  assign live      = inflight - drop;
  assign occupancy = ADDR_W'(fifo_count) + ADDR_W'(live);

  // Credit rule: buffered words plus live requests never exceed the buffer,
  // so a live response always finds a free slot.
  assign bus.imem_req  = rst_n && !br_valid
                      && (inflight < OUT_W'(MAX_OUTSTANDING))
                      && (occupancy < ADDR_W'(FIFO_DEPTH));
  assign bus.imem_addr = pc;
  assign accept        = bus.imem_req && bus.imem_ready;

  // Live requests are contiguous and end just below pc, so the oldest one
  // (the one being answered) sits live words back.
  assign resp_live        = bus.imem_rvalid && !br_valid && (drop == '0);
  assign resp_pc          = pc - (ADDR_W'(live) * PC_STEP);
  assign push_entry.instr = bus.imem_rdata;
  assign push_entry.pc    = resp_pc;

  assign bus.dec_valid = !fifo_empty && !br_valid;
  assign bus.dec_instr = fifo_head.instr;
  assign bus.dec_pc    = fifo_head.pc;
  assign fifo_pop      = bus.dec_valid && bus.dec_ready;

  fetch_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (br_valid),
    .push      (resp_live),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else if (br_valid) begin
      // Everything still outstanding after this cycle belongs to the old path.
      pc       <= branch_target(br_base_pc, br_delta);
      inflight <= inflight - OUT_W'(bus.imem_rvalid);
      drop     <= inflight - OUT_W'(bus.imem_rvalid);
    end else begin
      if (accept) begin
        pc <= pc + PC_STEP;
      end
      inflight <= inflight + OUT_W'(accept) - OUT_W'(bus.imem_rvalid);
      if (bus.imem_rvalid && (drop != '0)) begin
        drop <= drop - OUT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(resp_live && fifo_full));
      assert (drop <= inflight);
      assert (!(bus.imem_rvalid && (inflight == '0)));
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomised checks of fetch_unit against a latency-programmable
// memory model and an in-order {instr, pc} scoreboard.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        br_valid;
  logic [31:0] br_base_pc;
  logic [31:0] br_delta;

  int           passed = 0;
  int           total  = 0;
  int           lat    = 1;
  int           cyc    = 0;
  int           pops   = 0;
  logic [31:0]  mpc    = RESET_PC;
  fetch_entry_t sb [$];
  mreq_t        mq [$];

  fetch_unit_if bus ();

  fetch_unit #(
    .FIFO_DEPTH      (2),
    .MAX_OUTSTANDING (2),
    .RESET_PC        (RESET_PC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .br_valid   (br_valid),
    .br_base_pc (br_base_pc),
    .br_delta   (br_delta),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_dec(input string tag, input int budget);
    int n = 0;
    @(negedge clk);
    while (!bus.dec_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_seen"}, 32'(bus.dec_valid), 32'd1);
  endtask

  task automatic drain();
    tick();
    br_valid       = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dec_ready  = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    check("drain_empty", 32'(bus.dec_valid), 32'd0);
  endtask

  // In-order memory: accepted in cycle c, answered in cycle c+lat.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      cyc             <= 0;
      bus.imem_rvalid <= 1'b0;
      bus.imem_rdata  <= '0;
    end else begin
      if (bus.imem_rvalid) void'(mq.pop_front());
      if (bus.imem_req && bus.imem_ready) mq.push_back('{addr: bus.imem_addr, due: cyc + lat});
      if (mq.size() != 0 && mq[0].due <= cyc + 1) begin
        bus.imem_rvalid <= 1'b1;
        bus.imem_rdata  <= mem_word(mq[0].addr);
      end else begin
        bus.imem_rvalid <= 1'b0;
        bus.imem_rdata  <= '0;
      end
      cyc <= cyc + 1;
    end
  end

  // Scoreboard: accepted requests queue their expected word; a branch
  // discards everything not yet handed to Decode.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      mpc <= RESET_PC;
    end else begin
      if (bus.dec_valid && bus.dec_ready) begin
        check("dec_has_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          check("dec_pc", bus.dec_pc, sb[0].pc);
          check("dec_instr", bus.dec_instr, sb[0].instr);
          void'(sb.pop_front());
        end
      end
      if (br_valid) begin
        check("req_low_on_branch", 32'(bus.imem_req), 32'd0);
        sb.delete();
        mpc <= br_base_pc + (br_delta * 32'd4);
      end else if (bus.imem_req && bus.imem_ready) begin
        check("imem_addr", bus.imem_addr, mpc);
        sb.push_back('{instr: mem_word(mpc), pc: mpc});
        mpc <= mpc + 32'd4;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    br_valid       = 1'b0;
    br_base_pc     = '0;
    br_delta       = '0;
    bus.imem_ready = 1'b1;
    bus.dec_ready  = 1'b1;

    // Reset state, then 1-cycle memory streaming.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_imem_req", 32'(bus.imem_req), 32'd0);
    check("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
    check("rst_dec_instr", bus.dec_instr, 32'd0);
    check("rst_dec_pc", bus.dec_pc, 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("first_req", 32'(bus.imem_req), 32'd1);
    check("first_addr", bus.imem_addr, RESET_PC);
    check("lat_n_valid", 32'(bus.dec_valid), 32'd0);
    tick();
    @(negedge clk);
    check("lat_n1_valid", 32'(bus.dec_valid), 32'd0);
    tick();
    @(negedge clk);
    check("lat_n2_valid", 32'(bus.dec_valid), 32'd1);
    check("lat_n2_pc", bus.dec_pc, RESET_PC);
    check("lat_n2_instr", bus.dec_instr, mem_word(RESET_PC));
    repeat (20) tick();

    // Decode stall: buffer fills to two words and requests stop.
    dec_stall: begin
      bus.dec_ready = 1'b0;
      repeat (10) tick();
      @(negedge clk);
      check("stall_valid", 32'(bus.dec_valid), 32'd1);
      check("stall_req_off", 32'(bus.imem_req), 32'd0);
      tick();
      bus.imem_ready = 1'b0;
      bus.dec_ready  = 1'b1;
      pops = 0;
      repeat (6) begin
        @(negedge clk);
        if (bus.dec_valid) pops++;
        tick();
      end
      check("stall_buffered", 32'(pops), 32'd2);
      bus.imem_ready = 1'b1;
      repeat (15) tick();
    end

    // 3-cycle latency, two outstanding, branch lands with the first response.
    drain();
    tick();
    lat            = 3;
    bus.imem_ready = 1'b1;
    @(negedge clk);
    check("l3_req_a", 32'(bus.imem_req), 32'd1);
    tick();
    @(negedge clk);
    check("l3_req_a1", 32'(bus.imem_req), 32'd1);
    tick();
    @(negedge clk);
    check("l3_max_outstanding", 32'(bus.imem_req), 32'd0);
    tick();
    br_valid   = 1'b1;
    br_base_pc = 32'h0000_0010;
    br_delta   = 32'hFFFF_FFFC;
    @(negedge clk);
    check("l3_br_dec_valid", 32'(bus.dec_valid), 32'd0);
    tick();
    br_valid = 1'b0;
    @(negedge clk);
    check("l3_redirect_req", 32'(bus.imem_req), 32'd1);
    check("l3_redirect_addr", bus.imem_addr, 32'h0000_0000);
    wait_dec("l3_first", 12);
    check("l3_first_pc", bus.dec_pc, 32'h0000_0000);

    // Branch coincides with a response and a would-be Decode pop.
    drain();
    tick();
    lat            = 2;
    bus.imem_ready = 1'b1;
    repeat (3) tick();
    br_valid   = 1'b1;
    br_base_pc = 32'h0000_0100;
    br_delta   = 32'd8;
    @(negedge clk);
    check("co_br_dec_valid", 32'(bus.dec_valid), 32'd0);
    tick();
    br_valid = 1'b0;
    @(negedge clk);
    check("co_flushed", 32'(bus.dec_valid), 32'd0);
    check("co_req", 32'(bus.imem_req), 32'd1);
    check("co_addr", bus.imem_addr, 32'h0000_0120);
    wait_dec("co_first", 12);
    check("co_first_pc", bus.dec_pc, 32'h0000_0120);

    // Wrapping target, then memory back-pressure holds the request.
    drain();
    tick();
    br_valid   = 1'b1;
    br_base_pc = 32'hFFFF_FFFC;
    br_delta   = 32'd2;
    tick();
    br_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_req_held", 32'(bus.imem_req), 32'd1);
      check("bp_addr_held", bus.imem_addr, 32'h0000_0004);
      tick();
    end
    bus.imem_ready = 1'b1;
    wait_dec("wrap_first", 12);
    check("wrap_first_pc", bus.dec_pc, 32'h0000_0004);

    // Asynchronous reset mid-stream.
    drain();
    tick();
    lat            = 3;
    bus.imem_ready = 1'b1;
    bus.dec_ready  = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check("pre_reset_valid", 32'(bus.dec_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_req", 32'(bus.imem_req), 32'd0);
    check("async_rst_valid", 32'(bus.dec_valid), 32'd0);
    check("async_rst_pc", bus.dec_pc, 32'd0);
    check("async_rst_instr", bus.dec_instr, 32'd0);
    repeat (2) tick();
    rst_n         = 1'b1;
    bus.dec_ready = 1'b1;
    @(negedge clk);
    check("restart_req", 32'(bus.imem_req), 32'd1);
    check("restart_addr", bus.imem_addr, RESET_PC);
    check("restart_valid", 32'(bus.dec_valid), 32'd0);
    wait_dec("restart_first", 12);
    check("restart_first_pc", bus.dec_pc, RESET_PC);
    check("restart_first_instr", bus.dec_instr, mem_word(RESET_PC));

    // Random back-pressure and branches on both sides.
    lat = 2;
    repeat (300) begin
      tick();
      bus.imem_ready = (($urandom % 4) != 0);
      bus.dec_ready  = (($urandom % 3) != 0);
      if (($urandom % 16) == 0) begin
        br_valid   = 1'b1;
        br_base_pc = $urandom() & 32'hFFFF_FFFC;
        br_delta   = 32'($urandom_range(0, 64)) - 32'd32;
      end else begin
        br_valid = 1'b0;
      end
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
